// File: rtl/pdp1_terminal_writer.sv
// Character-stream front end for the 64x32 terminal frame buffer: cursor tracking,
// CR/LF/BS, auto-wrap, and scrolling via a rotating top-row offset with row clear.
module pdp1_terminal_writer #(
  parameter logic [7:0] BLANK = 8'h00
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [7:0]  char_in,
  input  logic        char_valid,
  output logic        char_ready,
  output logic [10:0] wraddress,
  output logic [7:0]  data,
  output logic [4:0]  scroll_row,
  output logic [10:0] cursor_addr
);

  typedef enum logic [1:0] {CLEAR_ALL, IDLE, CLEAR_ROW} state_t;

  state_t      state, state_nx;
  logic [4:0]  cur_row, row_nx, top, top_nx, rclr, rclr_nx;
  logic [5:0]  cur_col, col_nx;
  logic [10:0] cnt, cnt_nx, wa_nx;
  logic [7:0]  data_nx;
  logic        ready_nx, fire, nl;
  logic [4:0]  phys_row;

  assign phys_row    = top + cur_row;
  assign cursor_addr = {phys_row, cur_col};
  assign scroll_row  = top;
  assign fire        = char_valid & char_ready;

  always_comb begin
    state_nx = state;
    row_nx   = cur_row;
    col_nx   = cur_col;
    top_nx   = top;
    rclr_nx  = rclr;
    cnt_nx   = cnt;
    wa_nx    = wraddress;
    data_nx  = data;
    nl       = 1'b0;
    case (state)
      CLEAR_ALL: begin
        wa_nx   = cnt;
        data_nx = BLANK;
        cnt_nx  = cnt + 11'd1;
        if (cnt == 11'h7FF) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end
      end
      CLEAR_ROW: begin
        wa_nx   = {rclr, cnt[5:0]};
        data_nx = BLANK;
        cnt_nx  = cnt + 11'd1;
        if (cnt[5:0] == 6'h3F) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end
      end
      IDLE: begin
        if (fire) begin
          if (char_in >= 8'h20) begin
            wa_nx   = cursor_addr;
            data_nx = char_in;
            col_nx  = cur_col + 6'd1;  // wraps 63 -> 0 on its own
            nl      = (cur_col == 6'h3F);
          end else if (char_in == 8'h0A) begin
            nl = 1'b1;
          end else if (char_in == 8'h0D) begin
            col_nx = '0;
          end else if (char_in == 8'h08) begin
            if (cur_col != 6'd0) col_nx = cur_col - 6'd1;
          end
          if (nl) begin
            if (cur_row != 5'd31) begin
              row_nx = cur_row + 5'd1;
            end else begin
              // Old top row becomes the new bottom row; clear it instead of moving data.
              top_nx   = top + 5'd1;
              rclr_nx  = top;
              cnt_nx   = '0;
              state_nx = CLEAR_ROW;
            end
          end
        end
      end
      default: state_nx = CLEAR_ALL;
    endcase
    // Ready lags entry to IDLE by one edge so the last clear write gets its own cycle.
    ready_nx = (state == IDLE) && (state_nx == IDLE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= CLEAR_ALL;
      cur_row    <= '0;
      cur_col    <= '0;
      top        <= '0;
      rclr       <= '0;
      cnt        <= '0;
      wraddress  <= '0;
      data       <= BLANK;
      char_ready <= 1'b0;
    end else begin
      state      <= state_nx;
      cur_row    <= row_nx;
      cur_col    <= col_nx;
      top        <= top_nx;
      rclr       <= rclr_nx;
      cnt        <= cnt_nx;
      wraddress  <= wa_nx;
      data       <= data_nx;
      char_ready <= ready_nx;
    end
  end

endmodule

// File: tb/tb_pdp1_terminal_writer.sv
// Directed bench for pdp1_terminal_writer: screen clear, typing, wrap, scroll, reset abort.
module tb_pdp1_terminal_writer;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [7:0]  char_in;
  logic        char_valid;
  logic        char_ready;
  logic [10:0] wraddress;
  logic [7:0]  data;
  logic [4:0]  scroll_row;
  logic [10:0] cursor_addr;

  int passed = 0;
  int total  = 0;

  pdp1_terminal_writer #(.BLANK(8'h00)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .char_in     (char_in),
    .char_valid  (char_valid),
    .char_ready  (char_ready),
    .wraddress   (wraddress),
    .data        (data),
    .scroll_row  (scroll_row),
    .cursor_addr (cursor_addr)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic send(input logic [7:0] c);
    char_in    = c;
    char_valid = 1'b1;
    tick();
    char_valid = 1'b0;
  endtask

  initial begin
    reset_n    = 1'b0;
    char_valid = 1'b0;
    char_in    = 8'h00;
    repeat (2) @(negedge clock);
    chk("rst_wraddress", 32'(wraddress), 32'h0);
    chk("rst_data", 32'(data), 32'h0);
    chk("rst_ready", 32'(char_ready), 32'h0);
    chk("rst_scroll", 32'(scroll_row), 32'h0);
    chk("rst_cursor", 32'(cursor_addr), 32'h0);

    // Full screen clear: writes 0..2047, ready rises on edge 2049.
    reset_n = 1'b1;
    for (int i = 0; i < 2048; i++) begin
      tick();
      chk("clr_all_addr", 32'(wraddress), 32'(i));
      chk("clr_all_data", 32'(data), 32'h0);
      chk("clr_all_ready", 32'(char_ready), 32'h0);
    end
    tick();
    chk("ready_after_clear", 32'(char_ready), 32'h1);

    // "A" then "B" back to back.
    send(8'h41);
    chk("A_addr", 32'(wraddress), 32'h000);
    chk("A_data", 32'(data), 32'h41);
    chk("A_ready", 32'(char_ready), 32'h1);
    send(8'h42);
    chk("B_addr", 32'(wraddress), 32'h001);
    chk("B_data", 32'(data), 32'h42);
    chk("B_cursor", 32'(cursor_addr), 32'h002);
    tick();
    tick();
    chk("hold_addr", 32'(wraddress), 32'h001);
    chk("hold_data", 32'(data), 32'h42);

    // CR, BS at column 0 saturates, no writes.
    send(8'h0D);
    chk("CR_cursor", 32'(cursor_addr), 32'h000);
    chk("CR_nowrite", 32'(wraddress), 32'h001);
    chk("CR_ready", 32'(char_ready), 32'h1);
    send(8'h08);
    chk("BS0_cursor", 32'(cursor_addr), 32'h000);
    chk("BS0_nowrite", 32'(wraddress), 32'h001);
    send(8'h43);
    chk("C_addr", 32'(wraddress), 32'h000);
    send(8'h08);
    chk("BS_cursor", 32'(cursor_addr), 32'h000);

    // 64 'A' fill row 0, then 'B' lands at start of row 1.
    for (int i = 0; i < 64; i++) begin
      send(8'h41);
      chk("row_fill_addr", 32'(wraddress), 32'(i));
      chk("row_fill_ready", 32'(char_ready), 32'h1);
    end
    send(8'h42);
    chk("wrap_addr", 32'(wraddress), 32'h040);
    chk("wrap_data", 32'(data), 32'h42);
    chk("wrap_cursor", 32'(cursor_addr), 32'h041);
    chk("wrap_noscroll", 32'(scroll_row), 32'h0);

    // Ignored control code.
    send(8'h01);
    chk("ctl_cursor", 32'(cursor_addr), 32'h041);
    chk("ctl_nowrite", 32'(wraddress), 32'h040);

    // Move to row 31, column 0.
    for (int i = 0; i < 30; i++) send(8'h0A);
    send(8'h0D);
    chk("row31_cursor", 32'(cursor_addr), 32'h7C0);
    chk("row31_scroll", 32'(scroll_row), 32'h0);
    chk("row31_ready", 32'(char_ready), 32'h1);

    // LF on the bottom row scrolls and clears physical row 0.
    send(8'h0A);
    chk("scroll_row", 32'(scroll_row), 32'h1);
    chk("scroll_ready_drop", 32'(char_ready), 32'h0);
    chk("scroll_nowrite", 32'(wraddress), 32'h040);
    for (int i = 0; i < 64; i++) begin
      if (i == 5) char_valid = 1'b1;  // held request while busy must not transfer
      if (i == 6) char_valid = 1'b0;
      tick();
      chk("clr_row_addr", 32'(wraddress), 32'(i));
      chk("clr_row_data", 32'(data), 32'h0);
      chk("clr_row_ready", 32'(char_ready), 32'h0);
    end
    tick();
    chk("clr_row_ready_back", 32'(char_ready), 32'h1);
    chk("scroll_cursor", 32'(cursor_addr), 32'h000);

    // Auto-wrap on the bottom row writes first, then scrolls.
    for (int i = 0; i < 63; i++) send(8'h78);
    chk("bottom_cursor", 32'(cursor_addr), 32'h03F);
    send(8'h78);
    chk("autowrap_addr", 32'(wraddress), 32'h03F);
    chk("autowrap_data", 32'(data), 32'h78);
    chk("autowrap_scroll", 32'(scroll_row), 32'h2);
    chk("autowrap_ready", 32'(char_ready), 32'h0);
    chk("autowrap_cursor", 32'(cursor_addr), 32'h040);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("clr_row2_addr", 32'(wraddress), 32'h040 + 32'(i));
    end

    // Reset mid row clear.
    reset_n = 1'b0;
    #1;
    chk("abort_wraddress", 32'(wraddress), 32'h0);
    chk("abort_data", 32'(data), 32'h0);
    chk("abort_ready", 32'(char_ready), 32'h0);
    chk("abort_scroll", 32'(scroll_row), 32'h0);
    chk("abort_cursor", 32'(cursor_addr), 32'h0);
    @(negedge clock);
    reset_n = 1'b1;
    tick();
    chk("restart_addr0", 32'(wraddress), 32'h0);
    tick();
    chk("restart_addr1", 32'(wraddress), 32'h1);
    chk("restart_ready", 32'(char_ready), 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pdp1_terminal_writer.md
# pdp1_terminal_writer

Character-stream front end for the teletype emulator screen. Accepts one 8-bit character per handshake and turns it into writes for the 64 x 32 terminal frame buffer. Tracks the cursor, handles CR/LF/BS and auto-wrap, and scrolls by rotating a row offset instead of moving data. On scroll it clears the newly exposed row; after reset it clears the whole screen. It sits directly upstream of the terminal frame buffer write port, and its `scroll_row` output feeds the video read-address logic.

## Interface
- `BLANK`, default 8'h00: character code written by screen and row clears.
- `clock` in, 1 bit: single system clock. All logic is on the rising edge.
- `reset_n` in, 1 bit: asynchronous, active-low reset.
- `char_in` in, 8 bits: character code from the typewriter emulation.
- `char_valid` in, 1 bit: `char_in` is valid this cycle.
- `char_ready` out, 1 bit: the block can accept a character. A transfer happens when `char_valid & char_ready`.
- `wraddress` out, 11 bits: frame buffer write address, `{phys_row[4:0], col[5:0]}`.
- `data` out, 8 bits: frame buffer write data.
- `scroll_row` out, 5 bits: physical row shown at the top of the screen. Video computes `phys_row = (scroll_row + screen_row) mod 32`.
- `cursor_addr` out, 11 bits: physical address of the current cursor cell, used for cursor display.

## Operation
- The frame buffer writes on every clock, with no write enable. Therefore `wraddress`/`data` are registered outputs that change only when a new write is intended. Otherwise they hold their last value, which makes the repeat write idempotent.
- State: `cur_row` (5 bits, logical row 0..31), `cur_col` (6 bits), `top` (5 bits, equal to `scroll_row`), clear counter (11 bits).
- `phys_row = top + cur_row` with 5-bit wrap. `cursor_addr = {phys_row, cur_col}`.
- FSM states:
  - CLEAR_ALL: writes `BLANK` to address 0..2047, one per cycle. `char_ready` = 0. Goes to IDLE after address 2047.
  - IDLE: `char_ready` = 1.
  - CLEAR_ROW: writes `BLANK` to `{row_to_clear, 0..63}`. `char_ready` = 0. Goes to IDLE after column 63.
- Character handling on an accepted transfer in IDLE:
  - Printable (`char_in >= 8'h20`): write `char_in` at `cursor_addr`, then advance. If `cur_col` = 63, `cur_col` becomes 0 and a newline is taken.
  - LF (8'h0A): newline.
  - CR (8'h0D): `cur_col` becomes 0. No write.
  - BS (8'h08): `cur_col` decrements, saturating at 0. No write.
  - Any other code below 8'h20: accepted and ignored.
- Newline:
  - If `cur_row` < 31, `cur_row` increments.
  - If `cur_row` = 31: `top` increments mod 32 and `cur_row` stays 31. `row_to_clear` = the old `top`, i.e. the new bottom row. Enter CLEAR_ROW.
- A printable character that auto-wraps on the bottom row writes the character first, then enters CLEAR_ROW.

## Timing
- Reset values (asynchronous): `wraddress` = 0, `data` = `BLANK`, `char_ready` = 0, `scroll_row` = 0, `cursor_addr` = 0, state CLEAR_ALL with counter 0.
- Reset asserted mid-operation aborts everything, including a partial clear. The full clear restarts after release.
- CLEAR_ALL:
  - First write appears on the first rising edge after `reset_n` release, as `wraddress` = 0.
  - The last write is at address 2047, 2048 cycles later.
  - `char_ready` goes to 1 on the following edge.
- Printable character: `wraddress`/`data` update on the edge that accepts it (1-cycle latency to the frame buffer port). The cursor update is on the same edge. `char_ready` stays 1, so back-to-back characters proceed at one per clock.
- Scroll:
  - `char_ready` drops on the edge that accepts the scrolling character.
  - `scroll_row` updates on that same edge.
  - Row-clear writes occupy the next 64 edges.
  - `char_ready` returns to 1 on the edge after the column-63 write. Total busy time is 65 cycles.
- `char_valid` while `char_ready` = 0 is not a transfer. The source must hold the character.

## Test plan
- Reset release, then count writes: `wraddress` steps 0..2047 with `data` = 8'h00. `char_ready` = 0 throughout and rises exactly 2049 edges after release.
- Send "A" (8'h41) then "B": writes at 0x000 and 0x001 on consecutive edges. `cursor_addr` = 0x002. Outputs hold {0x001, 8'h42} while idle.
- Send 64 x 8'h41 then 8'h42: last 'A' at 0x03F, 'B' at 0x040. No clear occurs.
- Send CR then BS: `cursor_addr` = 0x000 afterwards, with no extra writes and 1 cycle per character.
- Drive to row 31 and send LF: `scroll_row` 0 -> 1. The next 64 writes are 0x000..0x03F with `BLANK`, and `char_ready` = 0 for exactly 65 cycles. After that, `cursor_addr` = 0x000, i.e. physical row 0 = logical row 31.
- Assert `reset_n` = 0 in the middle of a CLEAR_ROW: all outputs return to reset values immediately, and CLEAR_ALL restarts from address 0.
